// File: rtl/rv32i_pkg.sv
// Shared RV32I control definitions: opcode values, FSM states, mux encodings
// and the instruction class used by the sequencer.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM = 2'd1;
  localparam logic [1:0] PC_SEL_ALU = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
  } cls_t;

  function automatic cls_t classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OPIMM:  return CLS_OPIMM;
      OPC_OP:     return CLS_OP;
      OPC_FENCE:  return CLS_FENCE;
      OPC_SYSTEM: return CLS_SYSTEM;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// Instruction/data memory request-acknowledge handshake between the
// sequencer (master) and the memory side (slave).
interface rv32i_ctrl_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/rv32i_ctrl_waitcnt.sv
// Acknowledge-wait timeout counter: counts enabled cycles, flags expiry on
// the cycle that would make the count reach LAT_MAX.
module rv32i_ctrl_waitcnt #(
  parameter int LAT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LAT_MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != W'(LAT_MAX)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == W'(LAT_MAX - 1));

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb stepping,
// datapath enables and selects, retire counter, halt on SYSTEM/illegal.
//
// state  | meaning
// RST    | held in reset, leaves on first edge after release
// FETCH  | imem request until acknowledged, IR load
// DECODE | latch instruction class, halt on SYSTEM/illegal
// EXEC   | ALU step; branch/fence retire here
// MEM    | dmem request until acknowledged; store retires here
// WB     | register write and PC update, retire
// HALT   | terminal until reset
module rv32i_ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int IMEM_LAT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32i_ctrl_fsm_if.master     mem,
  input  logic [6:0]           opcode,
  input  logic                 br_taken,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_imm,
  output logic                 halted,
  output logic                 bus_err,
  output logic [31:0]          instret,
  output logic [2:0]           state
);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic        halted_q, halted_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        wait_en, wait_clr, expired;

  assign wait_en  = ((state_q == ST_FETCH) && !mem.imem_ack) ||
                    ((state_q == ST_MEM)   && !mem.dmem_ack);
  assign wait_clr = (state_d != state_q);

  rv32i_ctrl_waitcnt #(.LAT_MAX(IMEM_LAT_MAX)) u_waitcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem.imem_ack) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d = classify(opcode);
        if ((cls_d == CLS_SYSTEM) || (cls_d == CLS_ILLEGAL)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH, CLS_FENCE: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
    instret_d = instret_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      cls_q     <= CLS_ILLEGAL;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  // Moore decode of state/class; only ir_en and the store pc_en see the acks.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_src_imm  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem.imem_req = 1'b1;
        ir_en        = mem.imem_ack;
      end
      ST_EXEC: begin
        alu_src_imm = (cls_q != CLS_OP) && (cls_q != CLS_BRANCH);
        if (cls_q == CLS_BRANCH) begin
          pc_en  = 1'b1;
          pc_sel = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
        end else if (cls_q == CLS_FENCE) begin
          pc_en = 1'b1;
        end
      end
      ST_MEM: begin
        alu_src_imm  = 1'b1;
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (cls_q == CLS_STORE);
        pc_en        = mem.dmem_ack && (cls_q == CLS_STORE);
      end
      ST_WB: begin
        alu_src_imm = (cls_q != CLS_OP);
        rf_we       = 1'b1;
        pc_en       = 1'b1;
        case (cls_q)
          CLS_LOAD:          wb_sel = WB_SEL_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_SEL_PC4;
          CLS_LUI:           wb_sel = WB_SEL_IMM;
          default:           wb_sel = WB_SEL_ALU;
        endcase
        case (cls_q)
          CLS_JAL:  pc_sel = PC_SEL_IMM;
          CLS_JALR: pc_sel = PC_SEL_ALU;
          default:  pc_sel = PC_SEL_PC4;
        endcase
      end
      default: ;
    endcase
  end

  assign halted  = halted_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed self-checking bench for rv32i_ctrl_fsm using real instruction
// encodings and a hand-driven memory handshake.
module tb_rv32i_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        ir_en, pc_en, rf_we, alu_src_imm, halted, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ret;

  rv32i_ctrl_fsm_if mem_if ();

  assign opcode = ins[6:0];

  rv32i_ctrl_fsm #(.IMEM_LAT_MAX(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mem_if),
    .opcode      (opcode),
    .br_taken    (br_taken),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .alu_src_imm (alu_src_imm),
    .halted      (halted),
    .bus_err     (bus_err),
    .instret     (instret),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH with zero-wait imem; runs one instruction through WB.
  task automatic run_wb(input logic [31:0] i, input logic [1:0] exp_wb,
                        input logic [1:0] exp_pc, input logic exp_imm, input string tag);
    ins = i;
    step();
    check_val({tag, "_decode"}, 32'(state), 32'd2);
    step();
    check_val({tag, "_exec"}, 32'(state), 32'd3);
    check_val({tag, "_alu_imm"}, 32'(alu_src_imm), 32'(exp_imm));
    step();
    check_val({tag, "_wb"}, 32'(state), 32'd5);
    check_val({tag, "_rf_we"}, 32'(rf_we), 32'd1);
    check_val({tag, "_pc_en"}, 32'(pc_en), 32'd1);
    check_val({tag, "_wb_sel"}, 32'(wb_sel), 32'(exp_wb));
    check_val({tag, "_pc_sel"}, 32'(pc_sel), 32'(exp_pc));
    step();
    exp_ret = exp_ret + 1;
    check_val({tag, "_fetch"}, 32'(state), 32'd1);
    check_val({tag, "_instret"}, instret, exp_ret);
    check_val({tag, "_rf_we_off"}, 32'(rf_we), 32'd0);
  endtask

  initial begin
    ins             = 32'h00700313;
    br_taken        = 1'b0;
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    exp_ret         = 32'd0;

    #12;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_imem_req", 32'(mem_if.imem_req), 32'd0);
    check_val("rst_outputs", {25'd0, ir_en, pc_en, rf_we, alu_src_imm, halted, bus_err, mem_if.dmem_req}, 32'd0);
    check_val("rst_instret", instret, 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_val("fetch_state", 32'(state), 32'd1);
    check_val("fetch_imem_req", 32'(mem_if.imem_req), 32'd1);
    check_val("fetch_ir_en", 32'(ir_en), 32'd1);

    run_wb(32'h00700313, 2'd0, 2'd0, 1'b1, "addi");

    // load with dmem_ack on the 4th MEM cycle
    ins = 32'h0002a203;
    mem_if.dmem_ack = 1'b0;
    step();
    step();
    check_val("lw_exec", 32'(state), 32'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        mem_if.dmem_ack = 1'b1;
        #1;
      end
      check_val("lw_mem_state", 32'(state), 32'd4);
      check_val("lw_dmem_req", 32'(mem_if.dmem_req), 32'd1);
      check_val("lw_dmem_we", 32'(mem_if.dmem_we), 32'd0);
      check_val("lw_pc_en", 32'(pc_en), 32'd0);
    end
    step();
    mem_if.dmem_ack = 1'b0;
    check_val("lw_wb", 32'(state), 32'd5);
    check_val("lw_wb_sel", 32'(wb_sel), 32'd1);
    check_val("lw_rf_we", 32'(rf_we), 32'd1);
    check_val("lw_dmem_req_off", 32'(mem_if.dmem_req), 32'd0);
    step();
    exp_ret = exp_ret + 1;
    check_val("lw_instret", instret, exp_ret);

    // branch taken / not taken
    for (int t = 1; t >= 0; t--) begin
      ins = 32'h00628463;
      br_taken = t[0];
      step();
      step();
      check_val("br_exec", 32'(state), 32'd3);
      check_val("br_pc_en", 32'(pc_en), 32'd1);
      check_val("br_pc_sel", 32'(pc_sel), 32'(t));
      check_val("br_rf_we", 32'(rf_we), 32'd0);
      check_val("br_alu_imm", 32'(alu_src_imm), 32'd0);
      step();
      exp_ret = exp_ret + 1;
      check_val("br_fetch", 32'(state), 32'd1);
      check_val("br_rf_we_after", 32'(rf_we), 32'd0);
      check_val("br_instret", instret, exp_ret);
    end
    br_taken = 1'b0;

    // zero-wait store: pc_en with the ack in MEM
    mem_if.dmem_ack = 1'b1;
    ins = 32'h0062a023;
    step();
    step();
    step();
    check_val("sw_mem", 32'(state), 32'd4);
    check_val("sw_dmem_we", 32'(mem_if.dmem_we), 32'd1);
    check_val("sw_pc_en", 32'(pc_en), 32'd1);
    check_val("sw_pc_sel", 32'(pc_sel), 32'd0);
    check_val("sw_rf_we", 32'(rf_we), 32'd0);
    step();
    exp_ret = exp_ret + 1;
    check_val("sw_fetch", 32'(state), 32'd1);
    check_val("sw_instret", instret, exp_ret);

    run_wb(32'h008000ef, 2'd2, 2'd1, 1'b1, "jal");
    run_wb(32'h000080e7, 2'd2, 2'd2, 1'b1, "jalr");
    run_wb(32'h000012b7, 2'd3, 2'd0, 1'b1, "lui");
    run_wb(32'h006282b3, 2'd0, 2'd0, 1'b0, "add");

    // reset mid-MEM on a stalled store
    mem_if.dmem_ack = 1'b0;
    ins = 32'h0062a023;
    step();
    step();
    step();
    check_val("rstmem_mem", 32'(state), 32'd4);
    check_val("rstmem_req_before", 32'(mem_if.dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmem_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    check_val("rstmem_dmem_we", 32'(mem_if.dmem_we), 32'd0);
    check_val("rstmem_state", 32'(state), 32'd0);
    check_val("rstmem_instret", instret, 32'd0);
    mem_if.dmem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_val("rstmem_no_pc_en", 32'(pc_en), 32'd0);
    end

    // illegal opcode
    ins = 32'h0000007f;
    mem_if.imem_ack = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_val("ill_ir_en", 32'(ir_en), 32'd1);
    step();
    check_val("ill_decode", 32'(state), 32'd2);
    step();
    check_val("ill_halt", 32'(state), 32'd6);
    check_val("ill_halted", 32'(halted), 32'd1);
    check_val("ill_bus_err", 32'(bus_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("ill_imem_req", 32'(mem_if.imem_req), 32'd0);
      check_val("ill_state", 32'(state), 32'd6);
      check_val("ill_instret", instret, 32'd0);
    end

    // imem timeout
    rst_n = 1'b0;
    mem_if.imem_ack = 1'b0;
    ins = 32'h00700313;
    #10;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_val("to_fetch", 32'(state), 32'd1);
    for (int k = 1; k < 15; k++) begin
      step();
      check_val("to_waiting", {30'd0, bus_err, (state == 3'd1)}, 32'd1);
    end
    step();
    check_val("to_bus_err", 32'(bus_err), 32'd1);
    check_val("to_halted", 32'(halted), 32'd1);
    check_val("to_state", 32'(state), 32'd6);
    check_val("to_imem_req", 32'(mem_if.imem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_fsm.md
# rv32i_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back around the existing decode, ALU, register-file and PC datapath. It drives the instruction-memory and data-memory request/acknowledge handshakes and produces every datapath enable and mux select. It also counts retired instructions and halts on SYSTEM or illegal opcodes.

## Interface
Parameters:
- `IMEM_LAT_MAX`, default 15: maximum acknowledge wait, in cycles, before `bus_err` is raised.

Ports (all single-bit unless stated):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `ins[6:0]` taken from the IR output.
- `br_taken`  in  1  branch-compare result from the ALU, valid in EXEC.
- `imem_ack`  in  1  instruction-memory acknowledge.
- `dmem_ack`  in  1  data-memory acknowledge.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data write enable (stores).
- `ir_en`  out  1  load the IR from instruction-memory read data.
- `pc_en`  out  1  load the PC from the `pc_sel` source.
- `pc_sel`  out  2  0 = PC+4, 1 = PC+imm, 2 = {alu[31:1],1'b0}.
- `rf_we`  out  1  register-file write enable.
- `wb_sel`  out  2  0 = ALU, 1 = dmem read data, 2 = PC+4, 3 = imm.
- `alu_src_imm`  out  1  ALU operand B is `imm` rather than rs2.
- `halted`  out  1  sticky; set by SYSTEM or illegal opcode.
- `bus_err`  out  1  sticky; set by an acknowledge timeout.
- `instret`  out  32  retired-instruction counter.
- `state`  out  3  current state, for debug.

## Operation
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- RST is held while `rst_n`=0. It moves to FETCH on the first clock edge after reset deasserts.
- FETCH
  - Asserts `imem_req`.
  - On a cycle where `imem_ack`=1: pulses `ir_en` and moves to DECODE.
- DECODE
  - Classifies `opcode` into a latched class register.
  - Recognised opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
  - SYSTEM or any other opcode: sets `halted` and moves to HALT.
  - Otherwise moves to EXEC.
- EXEC
  - `alu_src_imm`=1 for every class except OP and BRANCH.
  - BRANCH: `pc_en`=1, `pc_sel`=1 if `br_taken` else 0. Retires the instruction and moves to FETCH.
  - FENCE: `pc_en`=1, `pc_sel`=0. Retires and moves to FETCH.
  - LOAD or STORE: moves to MEM.
  - All other classes: move to WB.
- MEM
  - Asserts `dmem_req`; `dmem_we`=1 for STORE.
  - On `dmem_ack`, STORE: `pc_en`=1, `pc_sel`=0, retire, move to FETCH.
  - On `dmem_ack`, LOAD: move to WB.
- WB
  - `rf_we`=1 and `pc_en`=1 for one cycle, then retire and move to FETCH.
  - `wb_sel`: LOAD=1, JAL/JALR=2, LUI=3, everything else=0.
  - `pc_sel`: JAL=1, JALR=2, everything else=0.
- HALT is terminal; only reset leaves it. All outputs other than `halted`, `bus_err`, `instret` and `state` are 0 in HALT.
- Retire means `instret` increments by 1. It wraps from 0xFFFFFFFF to 0.
- Timeout: a wait counter counts cycles with a request asserted and no acknowledge. If it reaches `IMEM_LAT_MAX`, `bus_err` and `halted` are set and the FSM moves to HALT. The counter clears on every state change.

## Timing
- Every output is 0 in reset, including `instret`; `state`=RST.
- Outputs are Moore decodes of the state register and the latched class. No output depends combinationally on `imem_ack` or `dmem_ack`, except:
  - `ir_en` = FETCH & `imem_ack`.
  - `pc_en` in MEM = MEM & `dmem_ack` & STORE.
- A request stays high until the acknowledge is sampled. An acknowledge in the same cycle as the request counts, so zero-wait memory gives the minimum latencies.
- Cycles per instruction with zero wait states: BRANCH and FENCE 3, STORE 4, OP, OP-IMM, LUI, AUIPC, JAL and JALR 4, LOAD 5. Each acknowledge wait cycle adds 1.
- An acknowledge while no request is asserted is ignored.
- Reset asserted mid-instruction forces RST asynchronously: requests drop in the same cycle, and no retire or write occurs.
- `rf_we` and `pc_en` are each at most one cycle per instruction.

## Structure
- Package `rv32i_pkg`:
  - Opcode constants (`OPC_LUI` … `OPC_SYSTEM`).
  - State enum.
  - `wb_sel` and `pc_sel` encodings.
  - Class enum.
- Shared with the decode block so opcode values have a single source.
- Sub-module `rv32i_ctrl_waitcnt`: the timeout counter, with clear/enable inputs and an expiry output. The FSM and the output decode stay in `rv32i_ctrl_fsm`.

## Test plan
Drive `opcode` from real encodings.
- Reset release, zero-wait memory, `ins`=0x00700313 (addi): state sequence RST, FETCH, DECODE, EXEC, WB, FETCH. `rf_we`=1 and `wb_sel`=0 in WB; `instret`=1 after 4 cycles.
- Load 0x0002a203 with `dmem_ack` delayed 3 cycles: `dmem_req` high for 4 cycles, then WB with `wb_sel`=1. 8 cycles total; `instret`=1.
- Branch 0x00628463 with `br_taken`=1: `pc_en`=1 and `pc_sel`=1 in EXEC, `rf_we` never asserts. Repeat with `br_taken`=0: `pc_sel`=0.
- Opcode 0x7F (illegal): HALT reached 2 cycles after the acknowledge, `halted`=1, `imem_req` stays 0 afterwards, `instret` unchanged.
- `imem_ack` held 0 with `IMEM_LAT_MAX`=15: `bus_err`=1 and `halted`=1 exactly 15 cycles after FETCH entry.
- Assert `rst_n`=0 mid-MEM on a store: `dmem_req` and `dmem_we` drop in the same cycle, `state`=RST, `instret`=0, and no `pc_en` pulse occurs.
